// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks, appends the
// 0x80 marker, zero fill and the 64-bit big-endian bit length, and hands each
// block to the hash core over a valid/ready handshake.
//
// Byte i of a block lives in block[511-8*i -: 8]. Numbered MSB-first, that is
// the same placement as block[i*8 +: 8] on a [0:511] vector, so the port can be
// wired straight to a core whose input is declared [0:511].
module sha256_padder #(
    parameter int unsigned LEN_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         eom,
    output logic [511:0] block,
    output logic         block_valid,
    input  logic         block_ready,
    output logic         block_last
);

    typedef enum logic [1:0] {StFill, StPad, StPad2, StOut} state_e;

    state_e             state_q;
    logic [5:0]         idx_q;
    logic [LEN_W-1:0]   count_q;
    logic               need2_q;
    logic               eom_pend_q;
    logic [511:0]       block_q;
    logic               valid_q;
    logic               last_q;
    logic               in_ready_q;

    logic               accept;
    logic               eom_take;
    logic               handshake;
    logic [63:0]        len_bits;
    logic [511:0]       fill_blk;
    logic [511:0]       pad_blk;
    logic [511:0]       pad2_blk;

    assign in_ready    = in_ready_q;
    assign block       = block_q;
    assign block_valid = valid_q;
    assign block_last  = last_q;

    // Handshake qualifiers; in_ready_q is only high in StFill.
    always_comb begin
        accept    = in_valid && in_ready_q;
        eom_take  = eom && in_ready_q;
        handshake = valid_q && block_ready;
    end

    // Candidate block images: byte insert, first padding block, length-only block.
    always_comb begin
        // Bit length modulo 2^(LEN_W+3); LEN_W <= 61 keeps it inside 64 bits.
        len_bits = 64'(count_q) << 3;
        fill_blk = block_q;
        pad_blk  = '0;
        pad2_blk = {448'b0, len_bits};
        for (int i = 0; i < 64; i++) begin
            if (idx_q == 6'(i)) begin
                fill_blk[511-8*i -: 8] = in_data;
            end
            if (6'(i) < idx_q) begin
                pad_blk[511-8*i -: 8] = block_q[511-8*i -: 8];
            end else if (6'(i) == idx_q) begin
                pad_blk[511-8*i -: 8] = 8'h80;
            end else begin
                pad_blk[511-8*i -: 8] = 8'h00;
            end
        end
        if (idx_q <= 6'd55) begin
            pad_blk[63:0] = len_bits;
        end
    end

    // Control FSM with all state and outputs registered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StFill;
            idx_q      <= '0;
            count_q    <= '0;
            need2_q    <= 1'b0;
            eom_pend_q <= 1'b0;
            block_q    <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (accept) begin
                        block_q <= fill_blk;
                        idx_q   <= idx_q + 6'd1;
                        count_q <= count_q + LEN_W'(1);
                    end
                    if (accept && idx_q == 6'd63) begin
                        // Full block: emit raw data, remember a coincident eom.
                        state_q    <= StOut;
                        valid_q    <= 1'b1;
                        last_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        eom_pend_q <= eom_take;
                    end else if (eom_take) begin
                        state_q    <= StPad;
                        in_ready_q <= 1'b0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                StPad: begin
                    block_q <= pad_blk;
                    last_q  <= (idx_q <= 6'd55);
                    need2_q <= (idx_q > 6'd55);
                    valid_q <= 1'b1;
                    state_q <= StOut;
                end
                StPad2: begin
                    block_q <= pad2_blk;
                    last_q  <= 1'b1;
                    need2_q <= 1'b0;
                    valid_q <= 1'b1;
                    state_q <= StOut;
                end
                StOut: begin
                    if (handshake) begin
                        valid_q <= 1'b0;
                        if (need2_q) begin
                            state_q <= StPad2;
                        end else if (eom_pend_q) begin
                            // Message ended exactly on a block boundary: marker at byte 0.
                            idx_q      <= '0;
                            eom_pend_q <= 1'b0;
                            state_q    <= StPad;
                        end else begin
                            idx_q      <= '0;
                            in_ready_q <= 1'b1;
                            state_q    <= StFill;
                            if (last_q) begin
                                count_q <= '0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Randomized bench for sha256_padder: messages are padded by a queue-based
// reference model and every emitted block is compared in order.
module tb_sha256_padder;

    localparam int Limit = 3000;

    typedef struct {
        logic [511:0] blk;
        logic         last;
    } exp_t;

    logic         clk;
    logic         reset;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         eom;
    logic [511:0] block;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    bit   hold_ready;
    int   ready_pct;

    sha256_padder #(
        .LEN_W(32)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .eom        (eom),
        .block      (block),
        .block_valid(block_valid),
        .block_ready(block_ready),
        .block_last (block_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference padding: msg || 0x80 || zeros || 64-bit bit length, cut into 64-byte blocks.
    task automatic push_model(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bits;
        exp_t        e;
        int          nb;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[k*8 +: 8]);
        nb = p.size() / 64;
        for (int b = 0; b < nb; b++) begin
            e.blk = '0;
            for (int i = 0; i < 64; i++) e.blk[511-8*i -: 8] = p[b*64+i];
            e.last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_abc();
        exp_t e;
        e.blk = '0;
        e.blk[511 -: 32] = 32'h61626380;
        e.blk[63:0] = 64'h18;
        e.last = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic put_byte(input logic [7:0] d, input logic e);
        int g = 0;
        while ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            eom      = 1'b0;
            @(negedge clk);
        end
        in_data  = d;
        in_valid = 1'b1;
        eom      = e;
        while (!in_ready && g < Limit) begin
            @(negedge clk);
            g++;
        end
        check_eq("byte_wait_timeout", 512'(g >= Limit), 0);
        @(negedge clk);
        in_valid = 1'b0;
        eom      = 1'b0;
    endtask

    task automatic eom_only(input bit lat);
        int g = 0;
        in_valid = 1'b0;
        eom      = 1'b1;
        while (!in_ready && g < Limit) begin
            @(negedge clk);
            g++;
        end
        check_eq("eom_wait_timeout", 512'(g >= Limit), 0);
        @(negedge clk);
        eom = 1'b0;
        if (lat) begin
            check_eq("lat_pad_not_valid", block_valid, 0);
            @(negedge clk);
            check_eq("lat_out_valid", block_valid, 1);
        end
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit eom_last);
        for (int i = 0; i < msg.size(); i++) put_byte(msg[i], eom_last && (i == msg.size() - 1));
        if (!eom_last || msg.size() == 0) eom_only(1'b0);
    endtask

    task automatic wait_valid();
        int g = 0;
        while (!block_valid && g < Limit) begin
            @(negedge clk);
            g++;
        end
        check_eq("wait_valid", block_valid, 1);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_q.size() != 0 || block_valid) && g < Limit) begin
            @(negedge clk);
            g++;
        end
        check_eq("drain_left", 512'(exp_q.size()), 0);
    endtask

    // Consumer and block checker: random block_ready, in-order compare, hold stability.
    initial begin
        exp_t         e;
        bit           prev_stall = 1'b0;
        logic [511:0] prev_blk   = '0;
        logic         prev_last  = 1'b0;
        block_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall  = 1'b0;
                block_ready = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_eq("hold_valid", block_valid, 1);
                    check_eq("hold_block", block, prev_blk);
                    check_eq("hold_last", block_last, prev_last);
                end
                block_ready = hold_ready ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
                if (block_valid && block_ready) begin
                    check_eq("block_expected", 512'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("block", block, e.blk);
                        check_eq("block_last", block_last, e.last);
                    end
                end
                prev_stall = block_valid && !block_ready;
                prev_blk   = block;
                prev_last  = block_last;
            end
        end
    end

    initial begin
        logic [7:0] msg[$];
        exp_t       e;
        int         len;
        int         sizes[2];
        bit         el;
        reset      = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        eom        = 1'b0;
        hold_ready = 1'b1;
        ready_pct  = 70;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_block_valid", block_valid, 0);
        check_eq("rst_block_last", block_last, 0);
        check_eq("rst_block", block, 0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", in_ready, 1);
        hold_ready = 1'b0;

        // "abc" with separate eom
        msg = {8'h61, 8'h62, 8'h63};
        push_abc();
        send_msg(msg, 1'b0);
        drain();

        // empty message, with PAD/OUT latency check
        e.blk = '0;
        e.blk[511 -: 8] = 8'h80;
        e.last = 1'b1;
        exp_q.push_back(e);
        eom_only(1'b1);
        drain();

        // 55 and 56 bytes of 'a'
        msg = {};
        for (int i = 0; i < 55; i++) msg.push_back(8'h61);
        push_model(msg);
        send_msg(msg, 1'b0);
        msg.push_back(8'h61);
        push_model(msg);
        send_msg(msg, 1'b1);
        drain();

        // 64 bytes with eom on the last one, then "a"
        msg = {};
        for (int i = 0; i < 64; i++) msg.push_back(8'($urandom));
        push_model(msg);
        send_msg(msg, 1'b1);
        msg = {8'h61};
        push_model(msg);
        send_msg(msg, 1'b0);
        drain();

        // consumer stalls 20 cycles while a byte is offered
        hold_ready = 1'b1;
        msg = {};
        for (int i = 0; i < 67; i++) msg.push_back(8'($urandom));
        push_model(msg);
        for (int i = 0; i < 64; i++) put_byte(msg[i], 1'b0);
        wait_valid();
        in_data  = msg[64];
        in_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check_eq("stall_in_ready", in_ready, 0);
        end
        hold_ready = 1'b0;
        for (int i = 64; i < 67; i++) put_byte(msg[i], i == 66);
        drain();

        // reset mid-message and mid-emit
        sizes[0] = 10;
        sizes[1] = 64;
        for (int s = 0; s < 2; s++) begin
            hold_ready = 1'b1;
            for (int i = 0; i < sizes[s]; i++) put_byte(8'($urandom), 1'b0);
            if (sizes[s] == 64) wait_valid();
            reset = 1'b0;
            @(negedge clk);
            check_eq("mid_rst_in_ready", in_ready, 0);
            check_eq("mid_rst_valid", block_valid, 0);
            check_eq("mid_rst_last", block_last, 0);
            check_eq("mid_rst_block", block, 0);
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            check_eq("mid_rst_in_ready_up", in_ready, 1);
            hold_ready = 1'b0;
            msg = {8'h61, 8'h62, 8'h63};
            push_abc();
            send_msg(msg, 1'b0);
            drain();
        end

        // random messages, lengths biased around the 55/56/64 boundaries
        for (int m = 0; m < 30; m++) begin
            if ($urandom_range(0, 2) == 0) len = 50 + $urandom_range(0, 20);
            else len = $urandom_range(0, 150);
            msg = {};
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            ready_pct = $urandom_range(20, 100);
            el = (len > 0) && ($urandom_range(0, 1) == 1);
            push_model(msg);
            send_msg(msg, el);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
